// File: rtl/golden_nonce_reporter.sv
// Captures each new golden nonce from the mining core, buffers it in a small FIFO,
// and streams it to the host UART as a frame of SYNC_BYTE followed by four nonce bytes, MSB first.
module golden_nonce_reporter #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           golden_nonce,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [7:0]            overflow_count,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        B3,
        B2,
        B1,
        B0
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [31:0]             prev_nonce;
    logic [31:0]             shift_reg;
    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic [7:0]              drops;

    logic hit;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a hit when the FSM frees a slot on the same edge.
    assign hit  = (golden_nonce != prev_nonce);
    assign full = (count == FULL_COUNT);
    assign pop  = (state == IDLE) && (count != '0);
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= golden_nonce;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_nonce <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drops      <= '0;
        end else begin
            prev_nonce <= golden_nonce;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && (drops != 8'hFF)) begin
                drops <= drops + 1'b1;
            end
        end
    end

    // The head byte of the nonce always sits in the top of the shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                shift_reg <= mem[rd_ptr];
            end else if (tx_ready && (state != IDLE) && (state != SYNC)) begin
                shift_reg <= {shift_reg[23:0], 8'h00};
            end
        end
    end

    always_comb begin
        state_next = state;
        tx_data    = 8'h00;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) begin
                    state_next = B3;
                end
            end
            B3: begin
                tx_data = shift_reg[31:24];
                if (tx_ready) begin
                    state_next = B2;
                end
            end
            B2: begin
                tx_data = shift_reg[31:24];
                if (tx_ready) begin
                    state_next = B1;
                end
            end
            B1: begin
                tx_data = shift_reg[31:24];
                if (tx_ready) begin
                    state_next = B0;
                end
            end
            B0: begin
                tx_data = shift_reg[31:24];
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_valid       = (state != IDLE);
    assign busy           = (state != IDLE);
    assign fifo_count     = count;
    assign overflow_count = drops;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Self-checking bench for golden_nonce_reporter: directed vector table, corner-case
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_golden_nonce_reporter;

    localparam int         DEPTH = 8;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] golden_nonce;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  fifo_count;
    logic [7:0]  overflow_count;
    logic        busy;

    golden_nonce_reporter #(
        .DEPTH_LOG2 (3),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .golden_nonce   (golden_nonce),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .fifo_count     (fifo_count),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending nonces, bytes left in the current frame, drop counter.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_frame[$];
    logic [31:0] m_prev;
    int          m_ovf;

    logic [7:0]  got[$];
    logic [31:0] exp_nonces[$];

    typedef struct {
        logic [31:0] nonce;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        int          exp_count;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] nonce, input logic ready);
        golden_nonce = nonce;
        tx_ready     = ready;
    endtask

    task automatic modelReset();
        m_fifo.delete();
        m_frame.delete();
        m_prev = '0;
        m_ovf  = 0;
    endtask

    task automatic modelEdge();
        logic        do_pop;
        logic [31:0] n;
        do_pop = (m_frame.size() == 0) && (m_fifo.size() > 0);
        if (m_frame.size() > 0 && tx_ready) begin
            void'(m_frame.pop_front());
        end
        if (do_pop) begin
            n = m_fifo.pop_front();
            m_frame.push_back(SYNC);
            m_frame.push_back(n[31:24]);
            m_frame.push_back(n[23:16]);
            m_frame.push_back(n[15:8]);
            m_frame.push_back(n[7:0]);
        end
        if (golden_nonce != m_prev) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(golden_nonce);
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        m_prev = golden_nonce;
    endtask

    task automatic checkModel();
        checkOutput("tx_valid", 32'(tx_valid), 32'(m_frame.size() > 0));
        checkOutput("busy", 32'(busy), 32'(m_frame.size() > 0));
        checkOutput("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
        checkOutput("overflow_count", 32'(overflow_count), 32'(m_ovf));
        if (m_frame.size() > 0) begin
            checkOutput("tx_data", 32'(tx_data), 32'(m_frame[0]));
        end
    endtask

    task automatic stepClock();
        if (tx_valid && tx_ready) begin
            got.push_back(tx_data);
        end
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic doReset();
        reset_n      = 1'b0;
        golden_nonce = '0;
        tx_ready     = 1'b0;
        #1;
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_overflow", 32'(overflow_count), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        modelReset();
        got.delete();
        @(negedge clk);
        reset_n = 1'b1;
        stepClock();
    endtask

    task automatic drainAll(input int budget);
        int n = 0;
        tx_ready = 1'b1;
        while ((m_frame.size() > 0 || m_fifo.size() > 0) && n < budget) begin
            stepClock();
            n++;
        end
        checkOutput("drain_idle", {30'd0, busy, (fifo_count != 4'd0)}, 32'd0);
    endtask

    task automatic checkFrames();
        logic [31:0] n;
        checkOutput("frame_bytes", 32'(got.size()), 32'(exp_nonces.size() * 5));
        for (int i = 0; i < exp_nonces.size(); i++) begin
            if (5 * i + 4 < got.size()) begin
                n = {got[5*i+1], got[5*i+2], got[5*i+3], got[5*i+4]};
                checkOutput("frame_sync", 32'(got[5*i]), 32'(SYNC));
                checkOutput("frame_nonce", n, exp_nonces[i]);
            end
        end
    endtask

    initial begin
        logic       v;
        logic       r;
        logic [7:0] d;
        logic       found;

        vecs[0] = '{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 1};
        vecs[1] = '{32'h1234ABCD, 1'b1, 1'b1, 8'hA5, 0};
        vecs[2] = '{32'h1234ABCD, 1'b1, 1'b1, 8'h12, 0};
        vecs[3] = '{32'h1234ABCD, 1'b1, 1'b1, 8'h34, 0};
        vecs[4] = '{32'h1234ABCD, 1'b1, 1'b1, 8'hAB, 0};
        vecs[5] = '{32'h1234ABCD, 1'b1, 1'b1, 8'hCD, 0};
        vecs[6] = '{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 0};
        vecs[7] = '{32'h1234ABCD, 1'b1, 1'b0, 8'h00, 0};

        reset_n      = 1'b0;
        golden_nonce = '0;
        tx_ready     = 1'b0;
        #2;
        doReset();

        $display("[TB] basic frame vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].nonce, vecs[i].ready);
            stepClock();
            checkOutput("vec_valid", 32'(tx_valid), 32'(vecs[i].exp_valid));
            checkOutput("vec_count", 32'(fifo_count), 32'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                checkOutput("vec_data", 32'(tx_data), 32'(vecs[i].exp_data));
            end
        end
        exp_nonces = '{32'h1234ABCD};
        checkFrames();

        $display("[TB] toggled ready");
        got.delete();
        golden_nonce = 32'h11223344;
        for (int i = 0; i < 20; i++) begin
            tx_ready = (i % 2 == 0);
            v = tx_valid;
            r = tx_ready;
            d = tx_data;
            stepClock();
            if (v && !r) begin
                checkOutput("stall_valid", 32'(tx_valid), 32'd1);
                checkOutput("stall_stable", 32'(tx_data), 32'(d));
            end
        end
        exp_nonces = '{32'h11223344};
        checkFrames();

        $display("[TB] overflow and full push/pop");
        doReset();
        applyStimulus(32'hC0000000, 1'b0);
        stepClock();
        stepClock();
        for (int i = 1; i <= 10; i++) begin
            golden_nonce = 32'hD0000000 + 32'(i);
            stepClock();
        end
        checkOutput("ovf_fifo_full", 32'(fifo_count), 32'd8);
        checkOutput("ovf_dropped", 32'(overflow_count), 32'd2);
        got.delete();
        tx_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            stepClock();
            found = !busy && (fifo_count == 4'd8);
        end
        checkOutput("reach_full_idle", 32'(found), 32'd1);
        golden_nonce = 32'hEEEE0001;
        stepClock();
        checkOutput("fullpop_count", 32'(fifo_count), 32'd8);
        checkOutput("fullpop_ovf", 32'(overflow_count), 32'd2);
        checkOutput("fullpop_busy", 32'(busy), 32'd1);
        drainAll(200);
        exp_nonces.delete();
        exp_nonces.push_back(32'hC0000000);
        for (int i = 1; i <= 8; i++) begin
            exp_nonces.push_back(32'hD0000000 + 32'(i));
        end
        exp_nonces.push_back(32'hEEEE0001);
        checkFrames();

        $display("[TB] reset mid-frame");
        doReset();
        applyStimulus(32'hA1A1A1A1, 1'b0);
        stepClock();
        stepClock();
        golden_nonce = 32'hA2A2A2A2;
        stepClock();
        golden_nonce = 32'hA3A3A3A3;
        stepClock();
        golden_nonce = 32'hA4A4A4A4;
        stepClock();
        checkOutput("mid_queued", 32'(fifo_count), 32'd3);
        tx_ready = 1'b1;
        stepClock();
        stepClock();
        tx_ready = 1'b0;
        checkOutput("mid_before_reset", 32'(tx_valid), 32'd1);
        #2;
        reset_n      = 1'b0;
        golden_nonce = '0;
        #1;
        checkOutput("mid_async_valid", 32'(tx_valid), 32'd0);
        checkOutput("mid_async_count", 32'(fifo_count), 32'd0);
        modelReset();
        got.delete();
        @(negedge clk);
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepClock();
        end
        checkOutput("mid_no_bytes", 32'(got.size()), 32'd0);
        golden_nonce = 32'h55AA55AA;
        stepClock();
        drainAll(50);
        exp_nonces = '{32'h55AA55AA};
        checkFrames();

        $display("[TB] overflow saturation");
        doReset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            golden_nonce = 32'h70000000 + 32'(i);
            stepClock();
        end
        checkOutput("sat_ovf", 32'(overflow_count), 32'd255);
        for (int i = 1; i <= 5; i++) begin
            golden_nonce = 32'h78000000 + 32'(i);
            stepClock();
        end
        checkOutput("sat_no_wrap", 32'(overflow_count), 32'd255);

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 3000; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                golden_nonce = $urandom;
            end
            stepClock();
        end
        drainAll(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
